// File: rtl/spi_pkg.sv
// Shared types for the SPI byte streamer: byte type and sequencer state encoding.
package spi_pkg;

    typedef logic [7:0] spi_byte_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        GAP
    } streamer_state_t;

endpackage

// File: rtl/spi_fifo.sv
// Synchronous first-word-fall-through FIFO with async active-low reset and occupancy output.
module spi_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a push at full is still accepted then.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/spi_byte_streamer.sv
// Sequencer in front of spi_master: one transfer per queued TX byte, results captured into an RX FIFO.
module spi_byte_streamer
    import spi_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic [7:0]             rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    input  logic                   rx_enable,
    output logic                   starttx,
    output logic [7:0]             d,
    input  logic [7:0]             q,
    input  logic                   finished,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] tx_level,
    output logic [$clog2(DEPTH):0] rx_level,
    output logic                   timeout_err
);

    localparam int unsigned CNT_TOP = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_TOP + 1);

    streamer_state_t state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    spi_byte_t       d_q, d_d;

    spi_byte_t tx_head;
    logic      tx_full, tx_empty, tx_pop;
    logic      rx_full, rx_empty, rx_push;

    spi_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (tx_valid && tx_ready),
        .wdata_i (tx_data),
        .pop_i   (tx_pop),
        .rdata_o (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .level_o (tx_level)
    );

    spi_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (rx_push),
        .wdata_i (q),
        .pop_i   (rx_valid && rx_ready),
        .rdata_o (rx_data),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .level_o (rx_level)
    );

    assign tx_ready = !tx_full;
    assign rx_valid = !rx_empty;
    assign starttx  = (state_q == START);
    assign d        = d_q;
    assign busy     = (state_q != IDLE) || !tx_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
        end
    end

    // d is captured from the FIFO head on leaving IDLE so it is already stable in START.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        d_d         = d_q;
        tx_pop      = 1'b0;
        rx_push     = 1'b0;
        timeout_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (!tx_empty && (!rx_enable || !rx_full)) begin
                    d_d     = tx_head;
                    state_d = START;
                end
            end
            START: begin
                tx_pop  = 1'b1;
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (finished) begin
                    rx_push = rx_enable;
                    cnt_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    timeout_err = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_byte_streamer.sv
// Directed self-checking bench: loopback master on the main instance, hand-driven finished on a short-timeout instance.
module tb_spi_byte_streamer;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned GAP     = 2;
    localparam int unsigned FIN_DLY = 20;
    localparam int unsigned LW      = $clog2(DEPTH) + 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic [7:0]    tx_data, rx_data, d, q;
    logic          tx_valid, tx_ready, rx_valid, rx_ready, rx_enable;
    logic          starttx, finished, busy, timeout_err;
    logic [LW-1:0] tx_level, rx_level;

    // short-timeout instance
    logic [7:0]    t_tx_data, t_rx_data, t_d, t_q;
    logic          t_tx_valid, t_tx_ready, t_rx_valid, t_rx_ready, t_rx_enable;
    logic          t_starttx, t_finished, t_busy, t_timeout_err;
    logic [LW-1:0] t_tx_level, t_rx_level;

    spi_byte_streamer #(
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP),
        .TIMEOUT    (1024)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_enable   (rx_enable),
        .starttx     (starttx),
        .d           (d),
        .q           (q),
        .finished    (finished),
        .busy        (busy),
        .tx_level    (tx_level),
        .rx_level    (rx_level),
        .timeout_err (timeout_err)
    );

    spi_byte_streamer #(
        .DEPTH      (DEPTH),
        .GAP_CYCLES (0),
        .TIMEOUT    (16)
    ) u_dut_to (
        .clk         (clk),
        .reset       (reset),
        .tx_data     (t_tx_data),
        .tx_valid    (t_tx_valid),
        .tx_ready    (t_tx_ready),
        .rx_data     (t_rx_data),
        .rx_valid    (t_rx_valid),
        .rx_ready    (t_rx_ready),
        .rx_enable   (t_rx_enable),
        .starttx     (t_starttx),
        .d           (t_d),
        .q           (t_q),
        .finished    (t_finished),
        .busy        (t_busy),
        .tx_level    (t_tx_level),
        .rx_level    (t_rx_level),
        .timeout_err (t_timeout_err)
    );

    // Loopback spi_master model: finished (with q = sent byte) FIN_DLY cycles after starttx.
    logic        m_busy;
    int unsigned m_cnt;
    logic [7:0]  m_byte;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy   <= 1'b0;
            m_cnt    <= 0;
            m_byte   <= '0;
            finished <= 1'b0;
            q        <= '0;
        end else begin
            finished <= 1'b0;
            if (starttx) begin
                m_busy <= 1'b1;
                m_cnt  <= 1;
                m_byte <= d;
            end else if (m_busy) begin
                if (m_cnt == FIN_DLY - 1) begin
                    finished <= 1'b1;
                    q        <= m_byte;
                    m_busy   <= 1'b0;
                end
                m_cnt <= m_cnt + 1;
            end
        end
    end

    int unsigned cyc = 0;
    int unsigned n_start = 0;
    int unsigned starts[$];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (starttx) begin
            n_start <= n_start + 1;
            starts.push_back(cyc);
        end
    end

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        int unsigned k = 0;
        while (!tx_ready && k < 400) begin
            tick();
            k++;
        end
        tx_data  = b;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        int unsigned k = 0;
        while (!rx_valid && k < 200) begin
            tick();
            k++;
        end
        check(tag, 32'(rx_data), 32'(exp));
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int unsigned limit);
        int unsigned k = 0;
        while (busy && k < limit) begin
            tick();
            k++;
        end
        check(tag, 32'(busy), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int unsigned base;
        int unsigned k;

        tx_data = '0; tx_valid = 0; rx_ready = 0; rx_enable = 0;
        t_tx_data = '0; t_tx_valid = 0; t_rx_ready = 0; t_rx_enable = 0;
        t_finished = 0; t_q = 8'h3C;

        // reset values
        #23;
        check("rst_starttx", 32'(starttx), 0);
        check("rst_d", 32'(d), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_tx_ready", 32'(tx_ready), 1);
        check("rst_rx_valid", 32'(rx_valid), 0);
        check("rst_levels", 32'({tx_level, rx_level}), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        reset = 1'b1;
        tick();
        tick();

        // single byte
        rx_enable = 1'b1;
        base = n_start;
        push_byte(8'h41);
        check("single_no_early_start", 32'(starttx), 0);
        check("single_busy_queued", 32'(busy), 1);
        tick();
        check("single_start_lat2", 32'(starttx), 1);
        check("single_d", 32'(d), 'h41);
        k = 0;
        do begin
            tick();
            k++;
        end while (!finished && k < 40);
        check("single_fin_lat", k, FIN_DLY);
        check("single_d_held", 32'(d), 'h41);
        tick();
        check("single_rx_level", 32'(rx_level), 1);
        check("single_rx_data", 32'(rx_data), 'h41);
        check("single_busy_gap0", 32'(busy), 1);
        tick();
        check("single_busy_gap1", 32'(busy), 1);
        tick();
        check("single_busy_drop", 32'(busy), 0);
        check("single_one_start", n_start - base, 1);
        pop_expect("single_pop", 8'h41);
        check("single_rx_empty", 32'(rx_level), 0);

        // burst of DEPTH bytes
        starts.delete();
        for (int i = 1; i <= 8; i++) push_byte(8'(i));
        check("burst_tx_level", 32'(tx_level), 7);
        check("burst_tx_ready", 32'(tx_ready), 1);
        wait_idle("burst_idle", 400);
        check("burst_n_start", starts.size(), 8);
        for (int i = 1; i < 8 && i < starts.size(); i++)
            check($sformatf("burst_spacing%0d", i), starts[i] - starts[i-1], FIN_DLY + 2 + GAP);
        check("burst_rx_level", 32'(rx_level), 8);
        for (int i = 1; i <= 8; i++) pop_expect($sformatf("burst_rx%0d", i), 8'(i));

        // RX backpressure
        base = n_start;
        for (int i = 0; i < 10; i++) push_byte(8'h10 + 8'(i));
        k = 0;
        while (rx_level != 8 && k < 400) begin
            tick();
            k++;
        end
        check("bp_rx_full", 32'(rx_level), 8);
        repeat (40) tick();
        check("bp_eight_starts", n_start - base, 8);
        check("bp_tx_level", 32'(tx_level), 2);
        check("bp_busy_stalled", 32'(busy), 1);
        pop_expect("bp_rx0", 8'h10);
        k = 0;
        while (n_start - base < 9 && k < 10) begin
            tick();
            k++;
        end
        check("bp_ninth_start", n_start - base, 9);
        for (int i = 1; i < 10; i++) pop_expect($sformatf("bp_rx%0d", i), 8'h10 + 8'(i));
        wait_idle("bp_idle", 200);
        check("bp_total_starts", n_start - base, 10);

        // discard mode
        rx_enable = 1'b0;
        base = n_start;
        push_byte(8'hA5);
        push_byte(8'h5A);
        wait_idle("disc_idle", 200);
        check("disc_starts", n_start - base, 2);
        check("disc_rx_level", 32'(rx_level), 0);
        check("disc_rx_valid", 32'(rx_valid), 0);
        check("disc_last_d", 32'(d), 'h5A);

        // timeout instance: no master, finished driven by hand
        t_rx_enable = 1'b1;
        t_tx_data = 8'hC0; t_tx_valid = 1'b1;
        tick();
        t_tx_valid = 1'b0;
        tick();
        check("to_start0", 32'(t_starttx), 1);
        check("to_d0", 32'(t_d), 'hC0);
        for (int i = 1; i <= 8; i++) begin
            t_tx_data  = 8'hC0 + 8'(i);
            t_tx_valid = 1'b1;
            tick();
        end
        t_tx_valid = 1'b0;
        check("to_tx_full_level", 32'(t_tx_level), 8);
        check("to_tx_ready_low", 32'(t_tx_ready), 0);
        repeat (7) tick();
        check("to_no_early_err", 32'(t_timeout_err), 0);
        tick();
        check("to_err_at16", 32'(t_timeout_err), 1);
        check("to_err_d", 32'(t_d), 'hC0);
        tick();
        check("to_err_one_cycle", 32'(t_timeout_err), 0);
        tick();
        check("to_next_start", 32'(t_starttx), 1);
        check("to_next_d", 32'(t_d), 'hC1);
        repeat (4) tick();
        t_finished = 1'b1;
        tick();
        t_finished = 1'b0;
        check("to_fin_rx_level", 32'(t_rx_level), 1);
        check("to_fin_rx_data", 32'(t_rx_data), 'h3C);
        check("to_gap0_no_start", 32'(t_starttx), 0);
        tick();
        check("to_gap0_start", 32'(t_starttx), 1);
        check("to_gap0_d", 32'(t_d), 'hC2);
        k = 0;
        while (t_busy && k < 300) begin
            tick();
            k++;
        end
        check("to_idle", 32'(t_busy), 0);
        t_finished = 1'b1;
        tick();
        t_finished = 1'b0;
        tick();
        check("to_late_fin_ignored", 32'(t_rx_level), 1);
        check("to_late_fin_no_start", 32'(t_starttx), 0);

        // async reset during WAIT
        rx_enable = 1'b1;
        push_byte(8'h77);
        push_byte(8'h78);
        repeat (6) tick();
        check("ar_pre_d", 32'(d), 'h77);
        check("ar_pre_busy", 32'(busy), 1);
        #2;
        reset = 1'b0;
        #1;
        check("ar_starttx", 32'(starttx), 0);
        check("ar_d", 32'(d), 0);
        check("ar_busy", 32'(busy), 0);
        check("ar_tx_ready", 32'(tx_ready), 1);
        check("ar_levels", 32'({tx_level, rx_level}), 0);
        check("ar_rx_valid", 32'(rx_valid), 0);
        reset = 1'b1;
        base = n_start;
        repeat (40) tick();
        check("ar_no_start", n_start - base, 0);
        check("ar_post_levels", 32'({tx_level, rx_level}), 0);
        check("ar_post_busy", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
